// File: rtl/me_pkg.sv
// Shared constants and helpers for the motion-estimation processing elements.
package me_pkg;

  localparam int unsigned DEF_LANES     = 4;
  localparam int unsigned DEF_PIX_W     = 8;
  localparam int unsigned DEF_BLK_BEATS = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pe_ad_lane.sv
// One pixel lane: current/previous pixel registers and the registered absolute difference.
module pe_ad_lane #(
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_pre,
  input  logic             i_load_crt,
  input  logic [PIX_W-1:0] i_crt,
  input  logic [PIX_W-1:0] i_pre,
  output logic [PIX_W-1:0] o_crt,
  output logic [PIX_W-1:0] o_pre,
  output logic [PIX_W-1:0] o_ad_next,
  output logic [PIX_W-1:0] o_ad
);

  logic [PIX_W-1:0] r_crt;
  logic [PIX_W-1:0] r_pre;
  logic [PIX_W-1:0] r_ad;
  logic [PIX_W-1:0] w_ad;

  always_comb begin
    w_ad = (r_crt >= r_pre) ? (r_crt - r_pre) : (r_pre - r_crt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crt <= '0;
      r_pre <= '0;
      r_ad  <= '0;
    end else begin
      if (i_load_pre) r_pre <= i_pre;
      if (i_load_crt) r_crt <= i_crt;
      r_ad <= w_ad;
    end
  end

  assign o_crt     = r_crt;
  assign o_pre     = r_pre;
  assign o_ad_next = w_ad;
  assign o_ad      = r_ad;

endmodule

// File: rtl/pe_sad_row.sv
// Row SAD processing element: per-lane AD, row sum, and block accumulation
// with a one-cycle result pulse every BLK_BEATS accepted beats.
module pe_sad_row
  import me_pkg::*;
#(
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned PIX_W     = DEF_PIX_W,
  parameter int unsigned BLK_BEATS = DEF_BLK_BEATS,
  localparam int unsigned SAD_W    = PIX_W + clog2(LANES * BLK_BEATS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   crt_keep,
  input  logic                   flush,
  input  logic [LANES*PIX_W-1:0] crt_pixel_i,
  input  logic [LANES*PIX_W-1:0] pre_pixel_i,
  output logic [LANES*PIX_W-1:0] crt_pixel_o,
  output logic [LANES*PIX_W-1:0] pre_pixel_o,
  output logic [LANES*PIX_W-1:0] ad_o,
  output logic [SAD_W-1:0]       sad_o,
  output logic                   sad_valid
);

  localparam int unsigned CNT_W = (BLK_BEATS > 1) ? clog2(BLK_BEATS) : 1;

  logic [LANES*PIX_W-1:0] w_ad_next;
  logic [SAD_W-1:0]       w_row_sum;
  logic                   w_load_pre;
  logic                   w_load_crt;

  logic                   r_v1;
  logic                   r_v2;
  logic [SAD_W-1:0]       r_row_sum;
  logic [SAD_W-1:0]       r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic [SAD_W-1:0]       r_sad;
  logic                   r_sad_valid;

  assign w_load_pre = in_valid;
  assign w_load_crt = in_valid & ~crt_keep;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pe_ad_lane #(
      .PIX_W(PIX_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_load_pre(w_load_pre),
      .i_load_crt(w_load_crt),
      .i_crt     (crt_pixel_i[g*PIX_W +: PIX_W]),
      .i_pre     (pre_pixel_i[g*PIX_W +: PIX_W]),
      .o_crt     (crt_pixel_o[g*PIX_W +: PIX_W]),
      .o_pre     (pre_pixel_o[g*PIX_W +: PIX_W]),
      .o_ad_next (w_ad_next[g*PIX_W +: PIX_W]),
      .o_ad      (ad_o[g*PIX_W +: PIX_W])
    );
  end

  always_comb begin
    w_row_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_row_sum = w_row_sum + SAD_W'(w_ad_next[i*PIX_W +: PIX_W]);
    end
  end

  // Flush only kills the valid pipeline and accumulator; data regs keep
  // loading since nothing downstream consumes them without a valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_row_sum   <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sad       <= '0;
      r_sad_valid <= 1'b0;
    end else begin
      r_v1        <= in_valid & ~flush;
      r_v2        <= r_v1 & ~flush;
      r_row_sum   <= w_row_sum;
      r_sad_valid <= 1'b0;
      if (flush) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_v2) begin
        if (r_cnt == CNT_W'(BLK_BEATS - 1)) begin
          r_sad       <= r_acc + r_row_sum;
          r_sad_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= r_acc + r_row_sum;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign sad_o     = r_sad;
  assign sad_valid = r_sad_valid;

endmodule

// File: tb/tb_pe_sad_row.sv
// Directed bench for pe_sad_row with LANES=4, PIX_W=8, BLK_BEATS=4.
module tb_pe_sad_row;

  localparam int unsigned LANES = 4;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned BLK   = 4;
  localparam int unsigned SAD_W = 12;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   crt_keep;
  logic                   flush;
  logic [LANES*PIX_W-1:0] crt_pixel_i;
  logic [LANES*PIX_W-1:0] pre_pixel_i;
  logic [LANES*PIX_W-1:0] crt_pixel_o;
  logic [LANES*PIX_W-1:0] pre_pixel_o;
  logic [LANES*PIX_W-1:0] ad_o;
  logic [SAD_W-1:0]       sad_o;
  logic                   sad_valid;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pulses = 0;
  logic [11:0] last_sad = '0;
  int          last_pulse_cyc = 0;
  int          last_beat_cyc = 0;
  int          p0;

  pe_sad_row #(
    .LANES    (LANES),
    .PIX_W    (PIX_W),
    .BLK_BEATS(BLK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .crt_keep   (crt_keep),
    .flush      (flush),
    .crt_pixel_i(crt_pixel_i),
    .pre_pixel_i(pre_pixel_i),
    .crt_pixel_o(crt_pixel_o),
    .pre_pixel_o(pre_pixel_o),
    .ad_o       (ad_o),
    .sad_o      (sad_o),
    .sad_valid  (sad_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sad_valid) begin
      pulses         <= pulses + 1;
      last_sad       <= sad_o;
      last_pulse_cyc <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] rep(input logic [7:0] v);
    return {4{v}};
  endfunction

  task automatic drive(input logic v, input logic [7:0] c, input logic [7:0] p,
                       input logic k, input logic f);
    @(negedge clk);
    in_valid    = v;
    crt_pixel_i = rep(c);
    pre_pixel_i = rep(p);
    crt_keep    = k;
    flush       = f;
    if (v) last_beat_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic block(input logic [7:0] c, input logic [7:0] p);
    repeat (BLK) drive(1'b1, c, p, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; crt_keep = 1'b0; flush = 1'b0;
    crt_pixel_i = '0; pre_pixel_i = '0;
    #12;
    check_eq("rst_sad_o", sad_o, 0);
    check_eq("rst_sad_valid", sad_valid, 0);
    check_eq("rst_crt_o", crt_pixel_o, 0);
    check_eq("rst_ad_o", ad_o, 0);
    @(negedge clk); rst = 1'b0;
    idle(2);

    // Back-to-back block, latency measured from the edge sampling the last beat.
    p0 = pulses;
    block(8'd200, 8'd50);
    idle(6);
    check_eq("t1_pulses", pulses - p0, 1);
    check_eq("t1_sad", last_sad, 2400);
    check_eq("t1_ad", ad_o, rep(8'd150));
    check_eq("t1_latency", last_pulse_cyc - last_beat_cyc, 2);
    check_eq("t1_sad_hold", sad_o, 2400);
    check_eq("t1_valid_low", sad_valid, 0);

    p0 = pulses;
    block(8'd0, 8'd255);
    idle(6);
    check_eq("t2a_pulses", pulses - p0, 1);
    check_eq("t2a_sad_max", last_sad, 4080);
    block(8'd10, 8'd250);
    idle(6);
    check_eq("t2b_ad", ad_o, rep(8'd240));
    check_eq("t2b_sad", last_sad, 3840);

    p0 = pulses;
    drive(1'b1, 8'd100, 8'd100, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 8'd0, 8'd100, 1'b1, 1'b0);
    idle(6);
    check_eq("t3_crt_held", crt_pixel_o, rep(8'd100));
    check_eq("t3_pulses", pulses - p0, 1);
    check_eq("t3_sad", last_sad, 0);

    p0 = pulses;
    repeat (BLK) begin
      drive(1'b1, 8'd200, 8'd50, 1'b0, 1'b0);
      idle(2);
    end
    idle(5);
    check_eq("t4_pulses", pulses - p0, 1);
    check_eq("t4_sad", last_sad, 2400);
    check_eq("t4_latency", last_pulse_cyc - last_beat_cyc, 2);

    // Flush coincides with a valid beat; that beat must not count either.
    p0 = pulses;
    repeat (2) drive(1'b1, 8'd200, 8'd50, 1'b0, 1'b0);
    drive(1'b1, 8'd255, 8'd0, 1'b0, 1'b1);
    idle(4);
    check_eq("t5_no_pulse", pulses - p0, 0);
    check_eq("t5_sad_hold", sad_o, 2400);
    block(8'd1, 8'd0);
    idle(6);
    check_eq("t5_pulses", pulses - p0, 1);
    check_eq("t5_sad", last_sad, 16);

    p0 = pulses;
    repeat (2) drive(1'b1, 8'd200, 8'd50, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_crt", crt_pixel_o, 0);
    check_eq("t6_rst_pre", pre_pixel_o, 0);
    check_eq("t6_rst_ad", ad_o, 0);
    check_eq("t6_rst_sad", sad_o, 0);
    check_eq("t6_rst_valid", sad_valid, 0);
    @(negedge clk); rst = 1'b0;
    idle(1);
    block(8'd200, 8'd50);
    idle(6);
    check_eq("t6_pulses", pulses - p0, 1);
    check_eq("t6_sad", last_sad, 2400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
